writeback_regfile_gen: RTL

Parametrised writeback stage with integrated register file for the LC-3-class pipeline. It selects the writeback value (ALU, memory or PC result), writes it to the destination register, and updates the 3-bit N/Z/P condition code (`psr`). It provides `NUM_RD` registered read ports (`vsr`) with optional same-cycle write-to-read bypass. It generalises the fixed 16-bit, 2-read-port, 8-register writeback_out behaviour and sits between the execute/memaccess stages and the decode/execute operand path.

---
 rtl/writeback_regfile_gen.sv | 84 ++++++++
 1 files changed

// File: rtl/writeback_regfile_gen.sv
// rtl/writeback_regfile_gen.sv - writeback select, register file, condition code and registered read ports
module writeback_regfile_gen #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable_writeback,
  input  logic [1:0]               W_Control,
  input  logic [DATA_W-1:0]        aluout,
  input  logic [DATA_W-1:0]        memout,
  input  logic [DATA_W-1:0]        pcout,
  input  logic [ADDR_W-1:0]        dr,
  input  logic [NUM_RD*ADDR_W-1:0] sr,
  output logic [NUM_RD*DATA_W-1:0] vsr,
  output logic [2:0]               psr,
  output logic                     wb_done,
  output logic                     err
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wdata;
  logic              commit;
  logic              reserved;

  // Source select; the reserved code never commits, so its value is irrelevant.
  always_comb begin
    wdata = aluout;
    case (W_Control)
      2'd0:    wdata = aluout;
      2'd1:    wdata = memout;
      2'd2:    wdata = pcout;
      default: wdata = aluout;
    endcase
  end

  assign reserved = enable_writeback && (W_Control == 2'd3);
  assign commit   = enable_writeback && (W_Control != 2'd3);

  // Register file write; reset clears every entry and beats any concurrent write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (commit) begin
      regs[dr] <= wdata;
    end
  end

  // Condition code, completion pulse and sticky reserved-select flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      psr     <= 3'b010;
      wb_done <= 1'b0;
      err     <= 1'b0;
    end else begin
      wb_done <= commit;
      if (commit) begin
        if (wdata[DATA_W-1])   psr <= 3'b100;
        else if (wdata == '0)  psr <= 3'b010;
        else                   psr <= 3'b001;
      end
      if (reserved) err <= 1'b1;
    end
  end

  // Read lanes sample every edge; a same-edge write to the addressed register
  // is forwarded only when bypass is enabled, otherwise the old value is seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      vsr <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if ((BYPASS != 0) && commit && (dr == sr[i*ADDR_W +: ADDR_W]))
          vsr[i*DATA_W +: DATA_W] <= wdata;
        else
          vsr[i*DATA_W +: DATA_W] <= regs[sr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule
